axi_lite_arbiter_2to1: RTL and testbench

- Shares one downstream AXI-lite slave between two upstream AXI-lite masters.
- Write and read paths are arbitrated independently with round-robin priority.
- Each path allows one outstanding transaction. A write may overlap a read.
- Sits between masters and an AXI-lite buffer or register slave; no data buffering inside.

---
 rtl/axi_lite_arb_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 34 +++
 rtl/axi_lite_arbiter_2to1.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_lite_arbiter_2to1.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_arb_pkg.sv
// Shared types for the 2:1 AXI-lite arbiter: path FSM states, response codes, round-robin pick.
// Pure declarations, no logic or storage.
package axi_lite_arb_pkg;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // With both requesting, the side that was not served last wins; a lone requester always wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin picker; combinational pick, last-grant pointer updated on load_i.
// Pointer resets to 1 so requester 0 wins the first contention; no backpressure of its own.
module rr_arbiter2
    import axi_lite_arb_pkg::*;
(
    input  logic       ap_clk,
    input  logic       ap_rst,
    input  logic [1:0] req_i,
    input  logic       load_i,
    input  logic       gnt_i,
    output logic       pick_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        last_d = last_q;
        if (load_i) begin
            last_d = gnt_i;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign pick_o = rr_pick(req_i, last_q);

endmodule

// File: rtl/axi_lite_arbiter_2to1.sv
// Shares one AXI-lite slave between two masters; write and read paths arbitrated independently.
// One idle arbitration cycle per transaction, channels otherwise pass through; slave stalls propagate to the granted master only.
module axi_lite_arbiter_2to1
    import axi_lite_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    // requester 0
    input  logic                    m0_aw_vld_i,
    output logic                    m0_aw_rdy_o,
    input  logic [ADDR_WIDTH-1:0]   m0_aw_addr_i,
    input  logic                    m0_w_vld_i,
    output logic                    m0_w_rdy_o,
    input  logic [DATA_WIDTH-1:0]   m0_w_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m0_w_strb_i,
    output logic                    m0_b_vld_o,
    input  logic                    m0_b_rdy_i,
    output logic [1:0]              m0_b_resp_o,
    input  logic                    m0_ar_vld_i,
    output logic                    m0_ar_rdy_o,
    input  logic [ADDR_WIDTH-1:0]   m0_ar_addr_i,
    output logic                    m0_r_vld_o,
    input  logic                    m0_r_rdy_i,
    output logic [DATA_WIDTH-1:0]   m0_r_dat_o,
    output logic [1:0]              m0_r_resp_o,
    // requester 1
    input  logic                    m1_aw_vld_i,
    output logic                    m1_aw_rdy_o,
    input  logic [ADDR_WIDTH-1:0]   m1_aw_addr_i,
    input  logic                    m1_w_vld_i,
    output logic                    m1_w_rdy_o,
    input  logic [DATA_WIDTH-1:0]   m1_w_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m1_w_strb_i,
    output logic                    m1_b_vld_o,
    input  logic                    m1_b_rdy_i,
    output logic [1:0]              m1_b_resp_o,
    input  logic                    m1_ar_vld_i,
    output logic                    m1_ar_rdy_o,
    input  logic [ADDR_WIDTH-1:0]   m1_ar_addr_i,
    output logic                    m1_r_vld_o,
    input  logic                    m1_r_rdy_i,
    output logic [DATA_WIDTH-1:0]   m1_r_dat_o,
    output logic [1:0]              m1_r_resp_o,
    // shared slave
    output logic                    s_aw_vld_o,
    input  logic                    s_aw_rdy_i,
    output logic [ADDR_WIDTH-1:0]   s_aw_addr_o,
    output logic                    s_w_vld_o,
    input  logic                    s_w_rdy_i,
    output logic [DATA_WIDTH-1:0]   s_w_dat_o,
    output logic [DATA_WIDTH/8-1:0] s_w_strb_o,
    input  logic                    s_b_vld_i,
    output logic                    s_b_rdy_o,
    input  logic [1:0]              s_b_resp_i,
    output logic                    s_ar_vld_o,
    input  logic                    s_ar_rdy_i,
    output logic [ADDR_WIDTH-1:0]   s_ar_addr_o,
    input  logic                    s_r_vld_i,
    output logic                    s_r_rdy_o,
    input  logic [DATA_WIDTH-1:0]   s_r_dat_i,
    input  logic [1:0]              s_r_resp_i
);

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;
    logic      wr_gnt_q, wr_gnt_d;
    logic      rd_gnt_q, rd_gnt_d;
    logic      aw_done_q, aw_done_d;
    logic      w_done_q, w_done_d;
    logic      wr_load, rd_load;
    logic      wr_pick, rd_pick;
    logic [1:0] wr_req, rd_req;
    logic [1:0] m_aw_rdy, m_w_rdy, m_b_vld, m_ar_rdy, m_r_vld;
    logic      g_aw_vld, g_w_vld, g_b_rdy, g_ar_vld, g_r_rdy;
    logic      aw_hs, w_hs;

    assign wr_req = {m1_aw_vld_i, m0_aw_vld_i};
    assign rd_req = {m1_ar_vld_i, m0_ar_vld_i};

    rr_arbiter2 u_wr_arb (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .req_i  (wr_req),
        .load_i (wr_load),
        .gnt_i  (wr_gnt_q),
        .pick_o (wr_pick)
    );

    rr_arbiter2 u_rd_arb (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .req_i  (rd_req),
        .load_i (rd_load),
        .gnt_i  (rd_gnt_q),
        .pick_o (rd_pick)
    );

    assign g_aw_vld = wr_gnt_q ? m1_aw_vld_i : m0_aw_vld_i;
    assign g_w_vld  = wr_gnt_q ? m1_w_vld_i  : m0_w_vld_i;
    assign g_b_rdy  = wr_gnt_q ? m1_b_rdy_i  : m0_b_rdy_i;
    assign g_ar_vld = rd_gnt_q ? m1_ar_vld_i : m0_ar_vld_i;
    assign g_r_rdy  = rd_gnt_q ? m1_r_rdy_i  : m0_r_rdy_i;

    assign s_aw_addr_o = wr_gnt_q ? m1_aw_addr_i : m0_aw_addr_i;
    assign s_w_dat_o   = wr_gnt_q ? m1_w_dat_i   : m0_w_dat_i;
    assign s_w_strb_o  = wr_gnt_q ? m1_w_strb_i  : m0_w_strb_i;
    assign s_ar_addr_o = rd_gnt_q ? m1_ar_addr_i : m0_ar_addr_i;

    // Once a channel has handshaken it is masked so the slave never sees it twice.
    assign aw_hs = g_aw_vld & ~aw_done_q & s_aw_rdy_i;
    assign w_hs  = g_w_vld  & ~w_done_q  & s_w_rdy_i;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_gnt_d   = wr_gnt_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        wr_load    = 1'b0;
        s_aw_vld_o = 1'b0;
        s_w_vld_o  = 1'b0;
        s_b_rdy_o  = 1'b0;
        m_aw_rdy   = 2'b00;
        m_w_rdy    = 2'b00;
        m_b_vld    = 2'b00;
        case (wr_state_q)
            W_IDLE: begin
                if (|wr_req) begin
                    wr_gnt_d   = wr_pick;
                    wr_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                s_aw_vld_o         = g_aw_vld & ~aw_done_q;
                s_w_vld_o          = g_w_vld & ~w_done_q;
                m_aw_rdy[wr_gnt_q] = s_aw_rdy_i & ~aw_done_q;
                m_w_rdy[wr_gnt_q]  = s_w_rdy_i & ~w_done_q;
                aw_done_d          = aw_done_q | aw_hs;
                w_done_d           = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                s_b_rdy_o         = g_b_rdy;
                m_b_vld[wr_gnt_q] = s_b_vld_i;
                if (s_b_vld_i && g_b_rdy) begin
                    wr_load    = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_gnt_d   = rd_gnt_q;
        rd_load    = 1'b0;
        s_ar_vld_o = 1'b0;
        s_r_rdy_o  = 1'b0;
        m_ar_rdy   = 2'b00;
        m_r_vld    = 2'b00;
        case (rd_state_q)
            R_IDLE: begin
                if (|rd_req) begin
                    rd_gnt_d   = rd_pick;
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                s_ar_vld_o         = g_ar_vld;
                m_ar_rdy[rd_gnt_q] = s_ar_rdy_i;
                if (g_ar_vld && s_ar_rdy_i) begin
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                s_r_rdy_o         = g_r_rdy;
                m_r_vld[rd_gnt_q] = s_r_vld_i;
                if (s_r_vld_i && g_r_rdy) begin
                    rd_load    = 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            wr_gnt_q   <= 1'b0;
            rd_gnt_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_gnt_q   <= rd_gnt_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    assign m0_aw_rdy_o = m_aw_rdy[0];
    assign m1_aw_rdy_o = m_aw_rdy[1];
    assign m0_w_rdy_o  = m_w_rdy[0];
    assign m1_w_rdy_o  = m_w_rdy[1];
    assign m0_b_vld_o  = m_b_vld[0];
    assign m1_b_vld_o  = m_b_vld[1];
    assign m0_ar_rdy_o = m_ar_rdy[0];
    assign m1_ar_rdy_o = m_ar_rdy[1];
    assign m0_r_vld_o  = m_r_vld[0];
    assign m1_r_vld_o  = m_r_vld[1];

    // Response payloads reach only the granted master; the other sees zeros.
    assign m0_b_resp_o = (wr_state_q == W_RESP && !wr_gnt_q) ? s_b_resp_i : RESP_OKAY;
    assign m1_b_resp_o = (wr_state_q == W_RESP &&  wr_gnt_q) ? s_b_resp_i : RESP_OKAY;
    assign m0_r_resp_o = (rd_state_q == R_DATA && !rd_gnt_q) ? s_r_resp_i : RESP_OKAY;
    assign m1_r_resp_o = (rd_state_q == R_DATA &&  rd_gnt_q) ? s_r_resp_i : RESP_OKAY;
    assign m0_r_dat_o  = (rd_state_q == R_DATA && !rd_gnt_q) ? s_r_dat_i : '0;
    assign m1_r_dat_o  = (rd_state_q == R_DATA &&  rd_gnt_q) ? s_r_dat_i : '0;

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Directed bench for the 2:1 AXI-lite arbiter: grants, gating, concurrency, reset and B backpressure.
module tb_axi_lite_arbiter_2to1;

    logic ap_clk = 1'b0;
    logic ap_rst;

    logic [1:0]  m_aw_vld, m_w_vld, m_b_rdy, m_ar_vld, m_r_rdy;
    logic [5:0]  m_aw_addr [2];
    logic [5:0]  m_ar_addr [2];
    logic [31:0] m_w_dat [2];
    logic [3:0]  m_w_strb [2];
    wire  [1:0]  m_aw_rdy, m_w_rdy, m_b_vld, m_ar_rdy, m_r_vld;
    wire  [1:0]  m0_b_resp, m1_b_resp, m0_r_resp, m1_r_resp;
    wire  [31:0] m0_r_dat, m1_r_dat;

    logic        s_aw_rdy, s_w_rdy, s_b_vld, s_ar_rdy, s_r_vld;
    logic [1:0]  s_b_resp, s_r_resp;
    logic [31:0] s_r_dat;
    wire         s_aw_vld, s_w_vld, s_b_rdy, s_ar_vld, s_r_rdy;
    wire  [5:0]  s_aw_addr, s_ar_addr;
    wire  [31:0] s_w_dat;
    wire  [3:0]  s_w_strb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 ap_clk = ~ap_clk;

    axi_lite_arbiter_2to1 #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .m0_aw_vld_i  (m_aw_vld[0]),  .m0_aw_rdy_o (m_aw_rdy[0]), .m0_aw_addr_i (m_aw_addr[0]),
        .m0_w_vld_i   (m_w_vld[0]),   .m0_w_rdy_o  (m_w_rdy[0]),  .m0_w_dat_i   (m_w_dat[0]),
        .m0_w_strb_i  (m_w_strb[0]),
        .m0_b_vld_o   (m_b_vld[0]),   .m0_b_rdy_i  (m_b_rdy[0]),  .m0_b_resp_o  (m0_b_resp),
        .m0_ar_vld_i  (m_ar_vld[0]),  .m0_ar_rdy_o (m_ar_rdy[0]), .m0_ar_addr_i (m_ar_addr[0]),
        .m0_r_vld_o   (m_r_vld[0]),   .m0_r_rdy_i  (m_r_rdy[0]),  .m0_r_dat_o   (m0_r_dat),
        .m0_r_resp_o  (m0_r_resp),
        .m1_aw_vld_i  (m_aw_vld[1]),  .m1_aw_rdy_o (m_aw_rdy[1]), .m1_aw_addr_i (m_aw_addr[1]),
        .m1_w_vld_i   (m_w_vld[1]),   .m1_w_rdy_o  (m_w_rdy[1]),  .m1_w_dat_i   (m_w_dat[1]),
        .m1_w_strb_i  (m_w_strb[1]),
        .m1_b_vld_o   (m_b_vld[1]),   .m1_b_rdy_i  (m_b_rdy[1]),  .m1_b_resp_o  (m1_b_resp),
        .m1_ar_vld_i  (m_ar_vld[1]),  .m1_ar_rdy_o (m_ar_rdy[1]), .m1_ar_addr_i (m_ar_addr[1]),
        .m1_r_vld_o   (m_r_vld[1]),   .m1_r_rdy_i  (m_r_rdy[1]),  .m1_r_dat_o   (m1_r_dat),
        .m1_r_resp_o  (m1_r_resp),
        .s_aw_vld_o   (s_aw_vld),     .s_aw_rdy_i  (s_aw_rdy),    .s_aw_addr_o  (s_aw_addr),
        .s_w_vld_o    (s_w_vld),      .s_w_rdy_i   (s_w_rdy),     .s_w_dat_o    (s_w_dat),
        .s_w_strb_o   (s_w_strb),
        .s_b_vld_i    (s_b_vld),      .s_b_rdy_o   (s_b_rdy),     .s_b_resp_i   (s_b_resp),
        .s_ar_vld_o   (s_ar_vld),     .s_ar_rdy_i  (s_ar_rdy),    .s_ar_addr_o  (s_ar_addr),
        .s_r_vld_i    (s_r_vld),      .s_r_rdy_o   (s_r_rdy),     .s_r_dat_i    (s_r_dat),
        .s_r_resp_i   (s_r_resp)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_all();
        m_aw_vld = '0; m_w_vld = '0; m_b_rdy = '0; m_ar_vld = '0; m_r_rdy = '0;
        for (int i = 0; i < 2; i++) begin
            m_aw_addr[i] = '0; m_ar_addr[i] = '0; m_w_dat[i] = '0; m_w_strb[i] = '0;
        end
        s_aw_rdy = 0; s_w_rdy = 0; s_b_vld = 0; s_ar_rdy = 0; s_r_vld = 0;
        s_b_resp = '0; s_r_resp = '0; s_r_dat = '0;
    endtask

    // Drives a lone write from master m through the address phase; returns in the B phase.
    task automatic wr_to_resp(input int m);
        m_aw_vld[m] = 1'b1; m_w_vld[m] = 1'b1; s_aw_rdy = 1; s_w_rdy = 1;
        step();
        step();
        m_aw_vld[m] = 1'b0; m_w_vld[m] = 1'b0; s_aw_rdy = 0; s_w_rdy = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord [4];
        int cyc [4];
        int n_g;
        int aw_hs, w_hs;

        // reset state
        idle_all();
        ap_rst = 1;
        step();
        step();
        settle();
        chk("rst_mst", {m_aw_rdy, m_w_rdy, m_b_vld, m_ar_rdy, m_r_vld}, 0);
        chk("rst_slv", {s_aw_vld, s_w_vld, s_b_rdy, s_ar_vld, s_r_rdy}, 0);
        ap_rst = 0;
        step();

        // single write from m0
        m_aw_vld[0] = 1; m_aw_addr[0] = 6'h04; m_w_vld[0] = 1;
        m_w_dat[0] = 32'hDEADBEEF; m_w_strb[0] = 4'hF; m_b_rdy[0] = 1;
        settle();
        chk("t1_arb_cycle", {s_aw_vld, s_w_vld}, 0);
        step();
        chk("t1_aw_vld", s_aw_vld, 1);
        chk("t1_aw_addr", s_aw_addr, 6'h04);
        chk("t1_w_vld", s_w_vld, 1);
        chk("t1_w_dat", s_w_dat, 32'hDEADBEEF);
        chk("t1_w_strb", s_w_strb, 4'hF);
        s_aw_rdy = 1; s_w_rdy = 1;
        settle();
        chk("t1_aw_rdy", m_aw_rdy, 2'b01);
        chk("t1_w_rdy", m_w_rdy, 2'b01);
        step();
        m_aw_vld[0] = 0; m_w_vld[0] = 0; s_aw_rdy = 0; s_w_rdy = 0;
        s_b_vld = 1; s_b_resp = 2'b00;
        settle();
        chk("t1_b_vld", m_b_vld, 2'b01);
        chk("t1_b_resp", m0_b_resp, 2'b00);
        chk("t1_b_rdy", s_b_rdy, 1);
        chk("t1_m1_quiet", {m_aw_rdy[1], m_w_rdy[1], m_b_vld[1]}, 0);
        step();
        s_b_vld = 0;
        settle();
        chk("t1_done", {s_aw_vld, s_b_rdy, m_b_vld}, 0);

        // contention after reset: strict alternation, one transaction per 3 cycles
        ap_rst = 1;
        step();
        ap_rst = 0;
        idle_all();
        m_aw_vld = 2'b11; m_w_vld = 2'b11; m_b_rdy = 2'b11;
        m_aw_addr[0] = 6'h10; m_aw_addr[1] = 6'h14;
        s_aw_rdy = 1; s_w_rdy = 1; s_b_vld = 1;
        n_g = 0;
        for (int c = 0; c < 30 && n_g < 4; c++) begin
            settle();
            if (m_aw_rdy[0] || m_aw_rdy[1]) begin
                ord[n_g] = m_aw_rdy[1] ? 1 : 0;
                cyc[n_g] = c;
                n_g++;
            end
            step();
        end
        chk("t2_grants", n_g, 4);
        for (int i = 0; i < n_g; i++) begin
            chk($sformatf("t2_order%0d", i), ord[i], i % 2);
            if (i > 0) chk($sformatf("t2_gap%0d", i), cyc[i] - cyc[i-1], 3);
        end
        m_aw_vld = 0; m_w_vld = 0; s_aw_rdy = 0; s_w_rdy = 0;
        step();
        idle_all();

        // m1: W ahead of AW, slave takes AW two cycles before W
        m_w_vld[1] = 1; m_w_dat[1] = 32'hA5A50001; m_w_strb[1] = 4'h3; m_b_rdy[1] = 1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("t3_w_only%0d", k), {s_aw_vld, s_w_vld, m_w_rdy}, 0);
            step();
        end
        m_aw_vld[1] = 1; m_aw_addr[1] = 6'h20;
        s_aw_rdy = 1; s_w_rdy = 0;
        aw_hs = 0; w_hs = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) s_w_rdy = 1;
            settle();
            aw_hs += int'(s_aw_vld & s_aw_rdy);
            w_hs  += int'(s_w_vld & s_w_rdy);
            if (k == 1) chk("t3_gnt_m1", m_aw_rdy, 2'b10);
            if (k == 2) chk("t3_aw_masked", {s_aw_vld, m_aw_rdy}, 0);
            step();
        end
        m_aw_vld[1] = 0; m_w_vld[1] = 0; s_aw_rdy = 0; s_w_rdy = 0;
        s_b_vld = 1; s_b_resp = 2'b10;
        settle();
        chk("t3_aw_once", aw_hs, 1);
        chk("t3_w_once", w_hs, 1);
        chk("t3_b_vld", m_b_vld, 2'b10);
        chk("t3_b_resp", {m1_b_resp, m0_b_resp}, 4'b1000);
        step();
        s_b_vld = 0;
        settle();
        chk("t3_done", m_b_vld, 0);
        idle_all();

        // concurrent read (m0) and write (m1)
        m_ar_vld[0] = 1; m_ar_addr[0] = 6'h08; m_r_rdy[0] = 1;
        m_aw_vld[1] = 1; m_aw_addr[1] = 6'h0C; m_w_vld[1] = 1;
        m_w_dat[1] = 32'hCAFEF00D; m_w_strb[1] = 4'hF; m_b_rdy[1] = 1;
        s_aw_rdy = 1; s_w_rdy = 1; s_ar_rdy = 1;
        settle();
        chk("t4_arb_cycle", {s_aw_vld, s_ar_vld}, 0);
        step();
        chk("t4_ar", {s_ar_vld, s_ar_addr}, {1'b1, 6'h08});
        chk("t4_aw", {s_aw_vld, s_aw_addr}, {1'b1, 6'h0C});
        chk("t4_gnts", {m_ar_rdy, m_aw_rdy}, 4'b0110);
        step();
        m_ar_vld = 0; m_aw_vld = 0; m_w_vld = 0;
        s_aw_rdy = 0; s_w_rdy = 0; s_ar_rdy = 0;
        s_r_vld = 1; s_r_dat = 32'h12345678; s_r_resp = 2'b00; s_b_vld = 1; s_b_resp = 2'b00;
        settle();
        chk("t4_r_vld", m_r_vld, 2'b01);
        chk("t4_r_dat_m0", m0_r_dat, 32'h12345678);
        chk("t4_r_dat_m1", m1_r_dat, 32'h0);
        chk("t4_b_vld", m_b_vld, 2'b10);
        chk("t4_slv_rdy", {s_r_rdy, s_b_rdy}, 2'b11);
        step();
        s_r_vld = 0; s_b_vld = 0;
        settle();
        chk("t4_done", {s_r_rdy, s_b_rdy, m_r_vld, m_b_vld}, 0);
        idle_all();

        // reset in the B phase; pointer must return to favour m0
        m_b_rdy = 2'b01;
        wr_to_resp(0);
        s_b_vld = 1;
        settle();
        chk("t5_b_m0", m_b_vld, 2'b01);
        step();
        s_b_vld = 0; m_b_rdy = 2'b00;
        wr_to_resp(0);
        s_b_vld = 1;
        settle();
        chk("t5_b_pending", m_b_vld, 2'b01);
        ap_rst = 1;
        step();
        ap_rst = 0;
        settle();
        chk("t5_rst_mst", {m_aw_rdy, m_w_rdy, m_b_vld, m_ar_rdy, m_r_vld}, 0);
        chk("t5_rst_slv", {s_aw_vld, s_w_vld, s_b_rdy, s_ar_vld, s_r_rdy}, 0);
        s_b_vld = 0;
        m_aw_vld = 2'b11; m_w_vld = 2'b11;
        step();
        s_aw_rdy = 1; s_w_rdy = 1; m_b_rdy = 2'b01;
        settle();
        chk("t5_gnt_m0", m_aw_rdy, 2'b01);
        step();
        m_aw_vld[0] = 0; m_w_vld[0] = 0; s_b_vld = 1;
        step();
        s_b_vld = 0;

        // m1 granted next; its B is held off for 5 cycles while m0 waits
        step();
        step();
        m_aw_vld[1] = 0; m_w_vld[1] = 0; m_b_rdy = 2'b00; s_b_vld = 1;
        m_aw_vld[0] = 1; m_w_vld[0] = 1;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("t6_hold%0d", k), {m_b_vld, s_b_rdy, m_aw_rdy, s_aw_vld}, 6'b10_0_00_0);
            step();
        end
        m_b_rdy[1] = 1;
        settle();
        chk("t6_b_rdy", s_b_rdy, 1);
        step();
        s_b_vld = 0;
        settle();
        chk("t6_idle", {s_aw_vld, m_aw_rdy}, 0);
        step();
        chk("t6_next_m0", m_aw_rdy, 2'b01);
        idle_all();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
